wm_cycle_controller: RTL and testbench

Main wash-cycle sequencer for the washing-machine controller. Drives the 3-bit phase code consumed by the phase timer and advances on the timer's sig_Full / sig_Temperature / sig_Completed flags. Generates the actuator enables: valve, heater, motor, drain and door lock. Supports a configurable number of rinse passes and cancellation at any point.

---
 rtl/wm_pkg.sv | 42 ++++
 rtl/wm_edge_detect.sv | 28 ++
 rtl/wm_cycle_controller.sv | 252 +++++++++++++++++++++++++
 tb/tb_wm_cycle_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine controller: the 3-bit phase
// codes seen by both the cycle sequencer and the phase timer, the default
// phase durations used by the timer, and small helpers used by the sequencer.
package wm_pkg;

  // Phase code driven to the timer; the numeric values are part of the
  // timer interface and must not be reordered.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GAP   = 3'd1,
    FILL  = 3'd2,
    HEAT  = 3'd3,
    WASH  = 3'd4,
    RINSE = 3'd5,
    SPIN  = 3'd6,
    DONE  = 3'd7
  } wm_phase_e;

  // Default phase durations in clock cycles, consumed by the phase timer.
  localparam int FILL_CYCLES  = 16;
  localparam int HEAT_CYCLES  = 24;
  localparam int WASH_CYCLES  = 32;
  localparam int RINSE_CYCLES = 20;
  localparam int SPIN_CYCLES  = 24;

  // Index of each timer flag inside the 3-bit flag vector.
  localparam int FLAG_FULL = 0;
  localparam int FLAG_TEMP = 1;
  localparam int FLAG_COMP = 2;

  // True for phases whose length is measured by the timer.
  function automatic logic is_timed(input wm_phase_e ph);
    return (ph == FILL) || (ph == HEAT) || (ph == WASH) ||
           (ph == RINSE) || (ph == SPIN);
  endfunction

  // Two-bit increment that sticks at its maximum instead of wrapping.
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/wm_edge_detect.sv
// Registered rising-edge detector. The timer flags are sticky levels, so only
// a 0->1 transition is turned into a single-cycle event for the sequencer.
module wm_edge_detect #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] sig_in,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_q;
  logic [W-1:0] rise_q;

  // Remember the last sampled level and register the 0->1 pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      prev_q <= sig_in;
      rise_q <= sig_in & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/wm_cycle_controller.sv
// Wash-cycle sequencer: steps through fill/heat/wash/rinse/spin, inserts a
// one-cycle GAP code between timed phases so the timer clears its counters,
// and drives the actuator enables registered from the next phase.
// Optional build macro: WM_WATCHDOG_EN adds a per-phase watchdog that raises
// a sticky fault and returns to IDLE when a phase lasts TIMEOUT_CYCLES.
module wm_cycle_controller
  import wm_pkg::*;
#(
  parameter int RINSE_PASSES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       door_closed,
  input  logic       cancel,
  input  logic       sig_Full,
  input  logic       sig_Temperature,
  input  logic       sig_Completed,
  output logic [2:0] state,
  output logic       door_lock,
  output logic       water_valve,
  output logic       heater,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       drain,
  output logic       cycle_done,
  output logic       fault
);

  // Reject configurations the counters cannot represent.
  if (RINSE_PASSES < 1 || RINSE_PASSES > 3) begin : g_bad_rinse
    $error("RINSE_PASSES must be 1..3");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 2..255");
  end

  wm_phase_e  state_q, state_d;
  wm_phase_e  gap_tgt_q, gap_tgt_d;
  logic [1:0] rinse_q, rinse_d;

  logic [2:0] flag_rise;
  logic       ev_full, ev_temp, ev_comp;

  logic       door_lock_q, water_valve_q, heater_q;
  logic       motor_on_q, motor_fast_q, drain_q, cycle_done_q;
  logic       door_lock_d, water_valve_d, heater_d;
  logic       motor_on_d, motor_fast_d, drain_d, cycle_done_d;

  logic       start_blocked;
  logic       wd_expire;

  wm_edge_detect #(.W(3)) u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .sig_in  ({sig_Completed, sig_Temperature, sig_Full}),
    .rise    (flag_rise)
  );

  assign ev_full = flag_rise[FLAG_FULL];
  assign ev_temp = flag_rise[FLAG_TEMP];
  assign ev_comp = flag_rise[FLAG_COMP];

`ifdef WM_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_cnt_q;
  logic       fault_q;

  // The counter value reached on the last allowed cycle of a timed phase
  // forces the exit, so a phase never lasts longer than TIMEOUT_CYCLES.
  assign wd_expire     = is_timed(state_q) && (wd_cnt_q == WD_LAST);
  assign start_blocked = fault_q;

  // Phase-length counter (cleared on every phase change) and sticky fault.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        wd_cnt_q <= '0;
      end else if (is_timed(state_q)) begin
        wd_cnt_q <= wd_cnt_q + 8'd1;
      end
      if (wd_expire) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign fault = fault_q;
`else
  assign wd_expire     = 1'b0;
  assign start_blocked = 1'b0;
  assign fault         = 1'b0;
`endif

  // State, sequencing bookkeeping and registered actuator outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      gap_tgt_q     <= IDLE;
      rinse_q       <= '0;
      door_lock_q   <= 1'b0;
      water_valve_q <= 1'b0;
      heater_q      <= 1'b0;
      motor_on_q    <= 1'b0;
      motor_fast_q  <= 1'b0;
      drain_q       <= 1'b0;
      cycle_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_tgt_q     <= gap_tgt_d;
      rinse_q       <= rinse_d;
      door_lock_q   <= door_lock_d;
      water_valve_q <= water_valve_d;
      heater_q      <= heater_d;
      motor_on_q    <= motor_on_d;
      motor_fast_q  <= motor_fast_d;
      drain_q       <= drain_d;
      cycle_done_q  <= cycle_done_d;
    end
  end

  // Next phase: nominal sequencing, then cancel, then watchdog override.
  always_comb begin
    state_d   = state_q;
    gap_tgt_d = gap_tgt_q;
    rinse_d   = rinse_q;

    unique case (state_q)
      IDLE: begin
        // A fresh cycle always starts with the heated wash pass.
        rinse_d = '0;
        if (start && door_closed && !start_blocked) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (ev_full) begin
          state_d   = GAP;
          gap_tgt_d = (rinse_q == 2'd0) ? HEAT : RINSE;
        end
      end
      HEAT: begin
        if (ev_temp) begin
          state_d   = GAP;
          gap_tgt_d = WASH;
        end
      end
      WASH: begin
        if (ev_comp) begin
          state_d   = GAP;
          gap_tgt_d = FILL;
          rinse_d   = sat_inc(rinse_q);
        end
      end
      RINSE: begin
        if (ev_comp) begin
          state_d = GAP;
          if (int'(rinse_q) < RINSE_PASSES) begin
            gap_tgt_d = FILL;
            rinse_d   = sat_inc(rinse_q);
          end else begin
            gap_tgt_d = SPIN;
          end
        end
      end
      GAP: begin
        state_d = gap_tgt_q;
      end
      SPIN: begin
        if (ev_comp) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!door_closed || !start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Cancel drains the tub via SPIN; it outranks any flag event this cycle.
    if (cancel && (state_q != IDLE) && (state_q != SPIN) && (state_q != DONE)) begin
      state_d = SPIN;
      rinse_d = '0;
    end

    if (wd_expire) begin
      state_d = IDLE;
      rinse_d = '0;
    end
  end

  // Actuator decode from the next phase so outputs move with the state code.
  always_comb begin
    door_lock_d   = 1'b0;
    water_valve_d = 1'b0;
    heater_d      = 1'b0;
    motor_on_d    = 1'b0;
    motor_fast_d  = 1'b0;
    drain_d       = 1'b0;
    cycle_done_d  = 1'b0;

    unique case (state_d)
      IDLE: ;
      GAP: begin
        // Motion actuators coast through the gap; water and heat stop.
        door_lock_d  = 1'b1;
        motor_on_d   = motor_on_q;
        motor_fast_d = motor_fast_q;
        drain_d      = drain_q;
      end
      FILL: begin
        door_lock_d   = 1'b1;
        water_valve_d = 1'b1;
      end
      HEAT: begin
        door_lock_d = 1'b1;
        heater_d    = 1'b1;
      end
      WASH, RINSE: begin
        door_lock_d = 1'b1;
        motor_on_d  = 1'b1;
      end
      SPIN: begin
        door_lock_d  = 1'b1;
        motor_on_d   = 1'b1;
        motor_fast_d = 1'b1;
        drain_d      = 1'b1;
      end
      DONE: begin
        cycle_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign door_lock   = door_lock_q;
  assign water_valve = water_valve_q;
  assign heater      = heater_q;
  assign motor_on    = motor_on_q;
  assign motor_fast  = motor_fast_q;
  assign drain       = drain_q;
  assign cycle_done  = cycle_done_q;

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Directed bench for the wash-cycle sequencer; timer flags are driven by hand.
module tb_wm_cycle_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       door_closed = 1'b0;
  logic       cancel = 1'b0;
  logic       sig_Full = 1'b0;
  logic       sig_Temperature = 1'b0;
  logic       sig_Completed = 1'b0;
  logic [2:0] state;
  logic       door_lock, water_valve, heater, motor_on, motor_fast, drain;
  logic       cycle_done, fault;
  logic [7:0] outs;

  int errors = 0;
  int checks = 0;

  // Output vector: {door_lock, water_valve, heater, motor_on, motor_fast, drain, cycle_done, fault}
  localparam logic [7:0] O_IDLE  = 8'b0000_0000;
  localparam logic [7:0] O_FILL  = 8'b1100_0000;
  localparam logic [7:0] O_HEAT  = 8'b1010_0000;
  localparam logic [7:0] O_MOT   = 8'b1001_0000;
  localparam logic [7:0] O_GAPV  = 8'b1000_0000;
  localparam logic [7:0] O_SPIN  = 8'b1001_1100;
  localparam logic [7:0] O_DONE  = 8'b0000_0010;
  localparam logic [7:0] O_FAULT = 8'b0000_0001;

  always #5 clock = ~clock;

  assign outs = {door_lock, water_valve, heater, motor_on, motor_fast, drain, cycle_done, fault};

  wm_cycle_controller #(.RINSE_PASSES(2), .TIMEOUT_CYCLES(8)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .door_closed     (door_closed),
    .cancel          (cancel),
    .sig_Full        (sig_Full),
    .sig_Temperature (sig_Temperature),
    .sig_Completed   (sig_Completed),
    .state           (state),
    .door_lock       (door_lock),
    .water_valve     (water_valve),
    .heater          (heater),
    .motor_on        (motor_on),
    .motor_fast      (motor_fast),
    .drain           (drain),
    .cycle_done      (cycle_done),
    .fault           (fault)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] es, input logic [7:0] eo);
    checks++;
    assert (state === es) else begin
      errors++;
      $error("FAIL %s state got=%0d want=%0d", tag, state, es);
    end
    checks++;
    assert (outs === eo) else begin
      errors++;
      $error("FAIL %s outs got=%b want=%b", tag, outs, eo);
    end
  endtask

  task automatic set_flag(input int idx, input logic v);
    case (idx)
      0:       sig_Full = v;
      1:       sig_Temperature = v;
      default: sig_Completed = v;
    endcase
  endtask

  // Raise a timer flag: one edge to register the event (phase holds),
  // the next edge acts on it.
  task automatic fire(input int idx, input string tag,
                      input logic [2:0] hs, input logic [7:0] ho,
                      input logic [2:0] ns, input logic [7:0] no);
    set_flag(idx, 1'b1);
    tick();
    chk({tag, "_hold"}, hs, ho);
    tick();
    chk({tag, "_next"}, ns, no);
    set_flag(idx, 1'b0);
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    chk("reset", 3'd0, O_IDLE);
    reset_n = 1'b1;
    tick();
    chk("reset_rel", 3'd0, O_IDLE);

    // Nominal run, two rinse passes
    door_closed = 1'b1;
    start = 1'b1;
    tick();
    chk("t1_fill", 3'd2, O_FILL);
    start = 1'b0;
    fire(0, "t1_full", 3'd2, O_FILL, 3'd1, O_GAPV);
    tick(); chk("t1_heat", 3'd3, O_HEAT);
    fire(1, "t1_temp", 3'd3, O_HEAT, 3'd1, O_GAPV);
    tick(); chk("t1_wash", 3'd4, O_MOT);
    fire(2, "t1_wdone", 3'd4, O_MOT, 3'd1, O_MOT);
    tick(); chk("t1_fill2", 3'd2, O_FILL);
    fire(0, "t1_full2", 3'd2, O_FILL, 3'd1, O_GAPV);
    tick(); chk("t1_rinse1", 3'd5, O_MOT);
    fire(2, "t1_r1done", 3'd5, O_MOT, 3'd1, O_MOT);
    tick(); chk("t1_fill3", 3'd2, O_FILL);
    fire(0, "t1_full3", 3'd2, O_FILL, 3'd1, O_GAPV);
    tick(); chk("t1_rinse2", 3'd5, O_MOT);
    fire(2, "t1_r2done", 3'd5, O_MOT, 3'd1, O_MOT);
    tick(); chk("t1_spin", 3'd6, O_SPIN);
    fire(2, "t1_sdone", 3'd6, O_SPIN, 3'd7, O_DONE);
    tick(); chk("t1_idle", 3'd0, O_IDLE);

    // Start with door open is ignored; closing it starts the fill
    door_closed = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_open", 3'd0, O_IDLE);
    end
    door_closed = 1'b1;
    tick(); chk("t2_fill", 3'd2, O_FILL);
    cancel = 1'b1;
    tick(); chk("t2_cancel", 3'd6, O_SPIN);
    cancel = 1'b0;
    fire(2, "t2_sdone", 3'd6, O_SPIN, 3'd7, O_DONE);
    tick(); chk("t2_done_hold", 3'd7, O_DONE);
    door_closed = 1'b0;
    start = 1'b0;
    tick(); chk("t2_idle", 3'd0, O_IDLE);

    // Sticky sig_Completed: RINSE only leaves on a fresh edge
    door_closed = 1'b1;
    start = 1'b1;
    tick(); chk("t3_fill", 3'd2, O_FILL);
    start = 1'b0;
    fire(0, "t3_full", 3'd2, O_FILL, 3'd1, O_GAPV);
    tick(); chk("t3_heat", 3'd3, O_HEAT);
    fire(1, "t3_temp", 3'd3, O_HEAT, 3'd1, O_GAPV);
    tick(); chk("t3_wash", 3'd4, O_MOT);
    sig_Completed = 1'b1;
    tick(); chk("t3_wash_hold", 3'd4, O_MOT);
    tick(); chk("t3_gap", 3'd1, O_MOT);
    tick(); chk("t3_fill2", 3'd2, O_FILL);
    fire(0, "t3_full2", 3'd2, O_FILL, 3'd1, O_GAPV);
    tick(); chk("t3_rinse", 3'd5, O_MOT);
    repeat (3) begin
      tick();
      chk("t3_sticky", 3'd5, O_MOT);
    end
    sig_Completed = 1'b0;
    tick(); chk("t3_low", 3'd5, O_MOT);
    sig_Completed = 1'b1;
    tick(); chk("t3_edge", 3'd5, O_MOT);
    tick(); chk("t3_exit", 3'd1, O_MOT);
    sig_Completed = 1'b0;
    tick(); chk("t3_fill3", 3'd2, O_FILL);
    cancel = 1'b1;
    tick(); chk("t3_cancel", 3'd6, O_SPIN);
    tick(); chk("t3_cancel_spin", 3'd6, O_SPIN);
    cancel = 1'b0;
    fire(2, "t3_sdone", 3'd6, O_SPIN, 3'd7, O_DONE);
    tick(); chk("t3_idle", 3'd0, O_IDLE);

    // Cancel during HEAT, coinciding with a temperature event
    start = 1'b1;
    tick(); chk("t4_fill", 3'd2, O_FILL);
    start = 1'b0;
    fire(0, "t4_full", 3'd2, O_FILL, 3'd1, O_GAPV);
    tick(); chk("t4_heat", 3'd3, O_HEAT);
    sig_Temperature = 1'b1;
    tick(); chk("t4_heat_hold", 3'd3, O_HEAT);
    cancel = 1'b1;
    tick(); chk("t4_cancel", 3'd6, O_SPIN);
    cancel = 1'b0;
    sig_Temperature = 1'b0;
    fire(2, "t4_sdone", 3'd6, O_SPIN, 3'd7, O_DONE);
    tick(); chk("t4_idle", 3'd0, O_IDLE);

    // Asynchronous reset mid-WASH
    start = 1'b1;
    tick(); chk("t5_fill", 3'd2, O_FILL);
    start = 1'b0;
    fire(0, "t5_full", 3'd2, O_FILL, 3'd1, O_GAPV);
    tick(); chk("t5_heat", 3'd3, O_HEAT);
    fire(1, "t5_temp", 3'd3, O_HEAT, 3'd1, O_GAPV);
    tick(); chk("t5_wash", 3'd4, O_MOT);
    #2 reset_n = 1'b0;
    #1 chk("t5_async", 3'd0, O_IDLE);
    tick(); chk("t5_held", 3'd0, O_IDLE);
    reset_n = 1'b1;
    tick(); chk("t5_rel", 3'd0, O_IDLE);

`ifdef WM_WATCHDOG_EN
    // Watchdog: FILL without sig_Full times out after 8 cycles
    start = 1'b1;
    tick(); chk("t6_fill", 3'd2, O_FILL);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t6_filling", 3'd2, O_FILL);
    end
    tick(); chk("t6_fault", 3'd0, O_FAULT);
    start = 1'b1;
    repeat (2) begin
      tick();
      chk("t6_blocked", 3'd0, O_FAULT);
    end
    start = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
